rib_timer: RTL and testbench

RIB_TIMER -- requirements
Module: rib_timer

---
 rtl/rib_timer.sv | 180 ++++++++++++++++++
 tb/tb_rib_timer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rib_timer.sv
// rib_timer: memory-mapped 32-bit timer with a 16-bit prescaler and a compare
// interrupt, sitting behind the rib slave port. There are four registers:
//   0x0 CTRL  : EN(0) IE(1) ONESHOT(2) PEND(3, write-1-to-clear)
//   0x4 VALUE : free-running count, reloaded to 0 on a compare match
//   0x8 CMP   : compare limit
//   0xC PRESC : prescaler limit (16 bits)
// Read data is registered and reflects register contents as they stood before
// the edge, so a write and a read of the same register at one edge return the
// old value.

module rib_timer #(
   parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic [31:0] rd_addr_i,
   output logic [31:0] rd_data_o,
   output logic        irq_o
);

   // Register indices taken from address bits [3:2]
   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_VALUE = 2'd1;
   localparam logic [1:0] REG_CMP   = 2'd2;
   localparam logic [1:0] REG_PRESC = 2'd3;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE      = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_PEND    = 3;

   // Architectural state
   logic        ctrl_en;
   logic        ctrl_ie;
   logic        ctrl_oneshot;
   logic        ctrl_pend;
   logic [31:0] value_q;
   logic [31:0] cmp_q;
   logic [15:0] presc_q;
   logic [15:0] pcnt_q;

   // Decoded write strobes and counter events
   logic        wr_ctrl;
   logic        wr_value;
   logic        wr_cmp;
   logic        wr_presc;
   logic        en_rise;
   logic        tick;
   logic        cmp_event;
   logic [31:0] ctrl_word;
   logic [31:0] rd_mux;

   // Address bits outside [3:2] are deliberately ignored by the decoder
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr_i[31:4], wr_addr_i[1:0],
                               rd_addr_i[31:4], rd_addr_i[1:0]};

   // Write decode: one strobe per register, qualified by the write enable
   always_comb begin
      wr_ctrl  = 1'b0;
      wr_value = 1'b0;
      wr_cmp   = 1'b0;
      wr_presc = 1'b0;
      if (wr_en_i) begin
         case (wr_addr_i[3:2])
            REG_CTRL:  wr_ctrl  = 1'b1;
            REG_VALUE: wr_value = 1'b1;
            REG_CMP:   wr_cmp   = 1'b1;
            REG_PRESC: wr_presc = 1'b1;
            default:   ;
         endcase
      end
   end

   // Counter events: a tick fires when the prescaler reaches its limit, and a
   // compare event needs a tick that is not overridden by a software VALUE write
   always_comb begin
      en_rise   = wr_ctrl && wr_data_i[CTRL_EN] && !ctrl_en;
      tick      = ctrl_en && (pcnt_q == presc_q);
      cmp_event = tick && !wr_value && (value_q == cmp_q);
   end

   // Prescaler counter: held at 0 while disabled, restarted on an enable edge,
   // otherwise counts up to PRESC and wraps (16-bit wrap if PRESC shrank below it)
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= 16'd0;
      end else if (en_rise || !ctrl_en || tick) begin
         pcnt_q <= 16'd0;
      end else begin
         pcnt_q <= pcnt_q + 16'd1;
      end
   end

   // VALUE register: software write wins over the tick; on a match it reloads 0
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= 32'd0;
      end else if (wr_value) begin
         value_q <= wr_data_i;
      end else if (tick) begin
         if (cmp_event) begin
            value_q <= 32'd0;
         end else begin
            value_q <= value_q + 32'd1;
         end
      end
   end

   // CMP and PRESC are plain software-loaded limits
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_q   <= CMP_RST;
         presc_q <= 16'd0;
      end else begin
         if (wr_cmp) begin
            cmp_q <= wr_data_i;
         end
         if (wr_presc) begin
            presc_q <= wr_data_i[15:0];
         end
      end
   end

   // CTRL enable/config bits: a software write takes priority over the
   // one-shot auto-disable that happens on a compare event
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_en      <= 1'b0;
         ctrl_ie      <= 1'b0;
         ctrl_oneshot <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en      <= wr_data_i[CTRL_EN];
         ctrl_ie      <= wr_data_i[CTRL_IE];
         ctrl_oneshot <= wr_data_i[CTRL_ONESHOT];
      end else if (cmp_event && ctrl_oneshot) begin
         ctrl_en <= 1'b0;
      end
   end

   // Pending flag: a compare event sets it and beats a simultaneous W1C
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_pend <= 1'b0;
      end else if (cmp_event) begin
         ctrl_pend <= 1'b1;
      end else if (wr_ctrl && wr_data_i[CTRL_PEND]) begin
         ctrl_pend <= 1'b0;
      end
   end

   // Read mux over the pre-edge register contents
   always_comb begin
      ctrl_word = {28'd0, ctrl_pend, ctrl_oneshot, ctrl_ie, ctrl_en};
      rd_mux    = 32'd0;
      case (rd_addr_i[3:2])
         REG_CTRL:  rd_mux = ctrl_word;
         REG_VALUE: rd_mux = value_q;
         REG_CMP:   rd_mux = cmp_q;
         REG_PRESC: rd_mux = {16'd0, presc_q};
         default:   rd_mux = 32'd0;
      endcase
   end

   // Registered read data and interrupt level, both one cycle behind the state
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_o <= 32'd0;
         irq_o     <= 1'b0;
      end else begin
         rd_data_o <= rd_mux;
         irq_o     <= ctrl_pend & ctrl_ie;
      end
   end

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: directed, table-driven bench for rib_timer. Each vector drives
// one clock of bus activity and then compares the registered read data and
// irq, which reflect register state from before that edge.

module tb_rib_timer;

   localparam logic [31:0] CMP_INIT = 32'hA5A5_0F0F;

   logic        clk;
   logic        rst;
   logic        wr_en_i;
   logic [31:0] wr_addr_i;
   logic [31:0] wr_data_i;
   logic [31:0] rd_addr_i;
   logic [31:0] rd_data_o;
   logic        irq_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] ra;
      logic [31:0] exp_rd;
      logic        exp_irq;
      logic        chk_rd;
   } vec_t;

   vec_t vq[$];

   rib_timer #(.CMP_RST(CMP_INIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o),
      .irq_o     (irq_o)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of bus inputs, then settle just after the rising edge
   task automatic applyStimulus(input logic we, input logic [31:0] wa,
                                input logic [31:0] wd, input logic [31:0] ra);
      wr_en_i   = we;
      wr_addr_i = wa;
      wr_data_i = wd;
      rd_addr_i = ra;
      @(posedge clk);
      #1;
      wr_en_i = 1'b0;
   endtask

   // Compare outputs against the expected values for the step just applied
   task automatic checkOutput(input string name, input logic [31:0] exp_rd,
                              input logic exp_irq, input logic chk_rd);
      if (chk_rd) begin
         checks++;
         if (rd_data_o !== exp_rd) begin
            errors++;
            $display("[TB] FAIL %s rd_data: got 0x%08h expected 0x%08h", name, rd_data_o, exp_rd);
         end
      end
      checks++;
      if (irq_o !== exp_irq) begin
         errors++;
         $display("[TB] FAIL %s irq: got %0b expected %0b", name, irq_o, exp_irq);
      end
   endtask

   task automatic addv(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra, input logic [31:0] er,
                       input logic ei, input logic cr);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
      v.exp_rd = er; v.exp_irq = ei; v.chk_rd = cr;
      vq.push_back(v);
   endtask

   initial begin
      logic [31:0] f_addr [10];
      logic [31:0] f_exp  [10];

      // Basic count: CMP=3, PRESC=0, CTRL=EN|IE (upper junk bits ignored)
      addv(0, 32'h0,      32'h0,         32'h8,         CMP_INIT,      0, 1);
      addv(1, 32'h1008,   32'h3,         32'h8,         CMP_INIT,      0, 1);
      addv(1, 32'hC,      32'hABCD_0000, 32'h0FF0_0008, 32'h3,         0, 1);
      addv(1, 32'h0,      32'hFFFF_FFF3, 32'h4,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h1,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h2,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h3,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         1, 1);
      addv(0, 32'h0,      32'h0,         32'h0,         32'hB,         1, 1);
      addv(1, 32'h0,      32'h8,         32'h4,         32'h2,         1, 1);
      addv(0, 32'h0,      32'h0,         32'h0,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h3,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h3,         0, 1);
      // Prescale: PRESC=2, CMP=1, EN only
      addv(1, 32'h4,      32'h0,         32'hC,         32'h0,         0, 1);
      addv(1, 32'hC,      32'h2,         32'h4,         32'h0,         0, 1);
      addv(1, 32'h8,      32'h1,         32'hC,         32'h2,         0, 1);
      addv(1, 32'h0,      32'h1,         32'h8,         32'h1,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h1,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h1,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h0,         32'h1,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h0,         32'h9,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);
      addv(1, 32'h0,      32'h8,         32'h0,         32'h9,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h1,         0, 1);
      // One-shot: CTRL=0x7, CMP=2, PRESC=0
      addv(1, 32'h4,      32'h0,         32'h0,         32'h0,         0, 1);
      addv(1, 32'h8,      32'h2,         32'h4,         32'h0,         0, 1);
      addv(1, 32'hC,      32'h0,         32'hC,         32'h2,         0, 1);
      addv(1, 32'h0,      32'h7,         32'h0,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h1,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h2,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h0,         32'hE,         1, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         1, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         1, 1);
      addv(1, 32'h0,      32'h8,         32'h0,         32'hE,         1, 1);
      addv(0, 32'h0,      32'h0,         32'h0,         32'h0,         0, 1);
      addv(0, 32'h0,      32'h0,         32'h4,         32'h0,         0, 1);

      rst = 1'b1;
      wr_en_i = 1'b0; wr_addr_i = 32'h0; wr_data_i = 32'h0; rd_addr_i = 32'h0;
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h8);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h8);
      checkOutput("reset", 32'h0, 1'b0, 1'b1);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         applyStimulus(vq[i].we, vq[i].wa, vq[i].wd, vq[i].ra);
         checkOutput($sformatf("vec%0d", i), vq[i].exp_rd, vq[i].exp_irq, vq[i].chk_rd);
      end

      // W1C of PEND on the compare-event edge: set must win
      applyStimulus(1'b1, 32'h8, 32'h1, 32'h0);
      applyStimulus(1'b1, 32'h0, 32'h3, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h0, 32'hB, 32'h0);
      checkOutput("w1c_collide_pre", 32'h3, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      checkOutput("w1c_collide", 32'hB, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h0, 32'h8, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      checkOutput("w1c_cleared", 32'h0, 1'b0, 1'b1);

      // VALUE write on the tick edge that would have matched CMP
      applyStimulus(1'b1, 32'h8, 32'h2, 32'h0);
      applyStimulus(1'b1, 32'h0, 32'h3, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h4, 32'h10, 32'h4);
      checkOutput("valwr_pre", 32'h2, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h4);
      checkOutput("valwr_value", 32'h10, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      checkOutput("valwr_nopend", 32'h3, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0, 32'h0, 32'h0);

      // 32-bit wrap with CMP=5: no PEND at 0xFFFF_FFFF->0, PEND at 5->0
      f_addr = '{32'h4, 32'h4, 32'h4, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h0};
      f_exp  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2,
                 32'h3, 32'h4, 32'h5, 32'h0, 32'h9};
      applyStimulus(1'b1, 32'h8, 32'h5, 32'h0);
      applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFE, 32'h0);
      applyStimulus(1'b1, 32'h0, 32'h1, 32'h0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, f_addr[k]);
         checkOutput($sformatf("wrap%0d", k), f_exp[k], 1'b0, 1'b1);
      end

      // Read latency, then reset asserted mid-count against a concurrent write
      applyStimulus(1'b1, 32'h0, 32'h3, 32'h0);
      checkOutput("pre_rst_ctrl", 32'h9, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h8);
      checkOutput("rd_latency_cmp", 32'h5, 1'b1, 1'b1);
      rst = 1'b1;
      applyStimulus(1'b1, 32'h4, 32'h77, 32'h8);
      checkOutput("rst_midcount", 32'h0, 1'b0, 1'b1);
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h8);
      checkOutput("rst_cmp", CMP_INIT, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
      checkOutput("rst_ctrl", 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h4);
      checkOutput("rst_value", 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'hC);
      checkOutput("rst_presc", 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0, 32'h1, 32'h4);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h4);
      checkOutput("resume0", 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h4);
      checkOutput("resume1", 32'h1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
